apb_uart_arbiter: RTL and testbench

APB_UART_ARBITER -- requirements
Module: apb_uart_arbiter

---
 rtl/apb_uart_pkg.sv | 14 +
 rtl/apb_uart_arbiter_rr_arb2.sv | 34 +++
 rtl/apb_uart_arbiter.sv | 132 +++++++++++++
 tb/tb_apb_uart_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_uart_pkg.sv
// Shared types and reset/default constants for the APB-style UART arbiter.
package apb_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_t;

    localparam int   DEF_DATA_W      = 8;
    localparam int   DEF_TIMEOUT_CYC = 255;
    localparam logic PTR_RST         = 1'b0;

endpackage

// File: rtl/apb_uart_arbiter_rr_arb2.sv
// Two-way round-robin pick with a registered 1-bit priority pointer.
module rr_arb2
    import apb_uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic       grant_idx,
    output logic       valid
);

    logic ptr;

    always_comb begin
        valid     = |req;
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ptr;
            default: grant_idx = 1'b0;
        endcase
    end

    // The pointer always moves to the side that did not just win.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= PTR_RST;
        else if (advance)
            ptr <= ~grant_idx;
    end

endmodule

// File: rtl/apb_uart_arbiter.sv
// Two-requester arbiter driving a UART FSM through an IDLE/SETUP/ACCESS handshake.
// Optional ACCESS timeout is enabled by defining APB_UART_ARB_TIMEOUT_EN.
module apb_uart_arbiter
    import apb_uart_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic [1:0]        req_i,
    input  logic [1:0]        wr_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic [DATA_W-1:0] wdata1_i,
    input  logic              uart_run_flag,
    input  logic              PREADY_i,
    input  logic [DATA_W-1:0] PRDATA_i,
    output logic              transfer_o,
    output logic              PWRITE_o,
    output logic [DATA_W-1:0] PWDATA_o,
    output logic [1:0]        ack_o,
    output logic [1:0]        err_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              busy_o
);

    arb_state_t state;
    logic       gnt;
    logic       pick;
    logic       pick_valid;
    logic       start;

`ifdef APB_UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
    logic             timed_out;

    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));
`endif

    assign start = (state == ST_IDLE) && uart_run_flag && pick_valid;

    rr_arb2 u_rr (
        .clk       (PCLK),
        .rst       (PRESET),
        .req       (req_i),
        .advance   (start),
        .grant_idx (pick),
        .valid     (pick_valid)
    );

    // PWRITE_o/PWDATA_o double as the transfer latch; they are cleared on every return to IDLE.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state      <= ST_IDLE;
            gnt        <= 1'b0;
            transfer_o <= 1'b0;
            PWRITE_o   <= 1'b0;
            PWDATA_o   <= '0;
            ack_o      <= 2'b00;
            err_o      <= 2'b00;
            rdata_o    <= '0;
            busy_o     <= 1'b0;
`ifdef APB_UART_ARB_TIMEOUT_EN
            cnt        <= '0;
`endif
        end else begin
            transfer_o <= 1'b0;
            ack_o      <= 2'b00;
            err_o      <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        gnt        <= pick;
                        PWRITE_o   <= wr_i[pick];
                        PWDATA_o   <= pick ? wdata1_i : wdata0_i;
                        transfer_o <= 1'b1;
                        busy_o     <= 1'b1;
                        state      <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (!uart_run_flag) begin
                        err_o    <= gnt ? 2'b10 : 2'b01;
                        PWRITE_o <= 1'b0;
                        PWDATA_o <= '0;
                        busy_o   <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
`ifdef APB_UART_ARB_TIMEOUT_EN
                        cnt   <= '0;
`endif
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // Abort beats completion; completion beats timeout.
                    if (!uart_run_flag) begin
                        err_o    <= gnt ? 2'b10 : 2'b01;
                        PWRITE_o <= 1'b0;
                        PWDATA_o <= '0;
                        busy_o   <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (PREADY_i) begin
                        ack_o    <= gnt ? 2'b10 : 2'b01;
                        if (!PWRITE_o)
                            rdata_o <= PRDATA_i;
                        PWRITE_o <= 1'b0;
                        PWDATA_o <= '0;
                        busy_o   <= 1'b0;
                        state    <= ST_IDLE;
`ifdef APB_UART_ARB_TIMEOUT_EN
                    end else if (timed_out) begin
                        err_o    <= gnt ? 2'b10 : 2'b01;
                        PWRITE_o <= 1'b0;
                        PWDATA_o <= '0;
                        busy_o   <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_arbiter.sv
// Self-checking bench for apb_uart_arbiter: directed scenarios plus randomized transfers
// predicted by a transaction-level model (grant rule, outcome cycle, read-data holding).
module tb_apb_uart_arbiter;

    localparam int DW = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET = 1'b1;
    logic [1:0]    req_i = 2'b00;
    logic [1:0]    wr_i = 2'b00;
    logic [DW-1:0] wdata0_i = '0;
    logic [DW-1:0] wdata1_i = '0;
    logic          uart_run_flag = 1'b0;
    logic          PREADY_i = 1'b0;
    logic [DW-1:0] PRDATA_i = '0;
    logic          transfer_o;
    logic          PWRITE_o;
    logic [DW-1:0] PWDATA_o;
    logic [1:0]    ack_o;
    logic [1:0]    err_o;
    logic [DW-1:0] rdata_o;
    logic          busy_o;

    int errors = 0;
    int checks = 0;

    // Model state: which side wins a tie next, and the last completed read value.
    bit            ptr = 1'b0;
    logic [DW-1:0] exp_rdata = '0;

    apb_uart_arbiter #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .req_i         (req_i),
        .wr_i          (wr_i),
        .wdata0_i      (wdata0_i),
        .wdata1_i      (wdata1_i),
        .uart_run_flag (uart_run_flag),
        .PREADY_i      (PREADY_i),
        .PRDATA_i      (PRDATA_i),
        .transfer_o    (transfer_o),
        .PWRITE_o      (PWRITE_o),
        .PWDATA_o      (PWDATA_o),
        .ack_o         (ack_o),
        .err_o         (err_o),
        .rdata_o       (rdata_o),
        .busy_o        (busy_o)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    always @(negedge PCLK) begin
        if (!PRESET) begin
            checks++;
            if ((ack_o & err_o) !== 2'b00) begin
                errors++;
                $display("FAIL ack_err_overlap: ack_o=%b err_o=%b required no common bit", ack_o, err_o);
            end
        end
    end

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET   = 1'b1;
        req_i    = 2'b00;
        PREADY_i = 1'b0;
        step();
        PRESET    = 1'b0;
        ptr       = 1'b0;
        exp_rdata = '0;
    endtask

    // ready_n: ACCESS cycle (1-based) in which PREADY_i is high.
    // abort_at: -1 none, 0 run flag low in SETUP, n>=1 low in ACCESS cycle n.
    task automatic do_xfer(input logic [1:0] req, input logic [1:0] wr,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] rd_val, input int ready_n,
                           input int abort_at, input bit drop_mid, input bit hold,
                           input string tag);
        int            g;
        int            end_n;
        bit            exp_ack;
        logic          exp_pw;
        logic [DW-1:0] exp_pd;
        logic [1:0]    gbit;

        g      = (req == 2'b01) ? 0 : (req == 2'b10) ? 1 : int'(ptr);
        ptr    = (g == 0);
        gbit   = (g == 1) ? 2'b10 : 2'b01;
        exp_pw = wr[g];
        exp_pd = (g == 1) ? d1 : d0;

        exp_ack = 1'b1;
        end_n   = ready_n;
`ifdef APB_UART_ARB_TIMEOUT_EN
        if (TO < end_n) begin
            end_n   = TO;
            exp_ack = 1'b0;
        end
`endif
        if (abort_at >= 0 && abort_at <= end_n) begin
            end_n   = abort_at;
            exp_ack = 1'b0;
        end
        if (exp_ack && !exp_pw)
            exp_rdata = rd_val;

        req_i         = req;
        wr_i          = wr;
        wdata0_i      = d0;
        wdata1_i      = d1;
        uart_run_flag = 1'b1;
        PREADY_i      = 1'b0;
        step();

        checks++;
        if ({transfer_o, busy_o, ack_o, err_o} !== 6'b110000) begin
            errors++;
            $display("FAIL %s setup_ctrl: transfer/busy/ack/err=%b required 110000", tag,
                     {transfer_o, busy_o, ack_o, err_o});
        end
        checks++;
        if ({PWRITE_o, PWDATA_o} !== {exp_pw, exp_pd}) begin
            errors++;
            $display("FAIL %s setup_bus: pwrite=%b pwdata=%h required %b %h", tag,
                     PWRITE_o, PWDATA_o, exp_pw, exp_pd);
        end
        if (abort_at == 0)
            uart_run_flag = 1'b0;
        step();

        for (int n = 1; n <= end_n; n++) begin
            checks++;
            if ({transfer_o, busy_o, ack_o, err_o} !== 6'b010000) begin
                errors++;
                $display("FAIL %s access%0d_ctrl: transfer/busy/ack/err=%b required 010000", tag, n,
                         {transfer_o, busy_o, ack_o, err_o});
            end
            checks++;
            if ({PWRITE_o, PWDATA_o} !== {exp_pw, exp_pd}) begin
                errors++;
                $display("FAIL %s access%0d_bus: pwrite=%b pwdata=%h required %b %h", tag, n,
                         PWRITE_o, PWDATA_o, exp_pw, exp_pd);
            end
            if (drop_mid)
                req_i = 2'b00;
            if (n == ready_n) begin
                PREADY_i = 1'b1;
                PRDATA_i = rd_val;
            end else begin
                PREADY_i = 1'b0;
                PRDATA_i = DW'($urandom);
            end
            if (n == abort_at)
                uart_run_flag = 1'b0;
            step();
        end

        checks++;
        if (ack_o !== (exp_ack ? gbit : 2'b00)) begin
            errors++;
            $display("FAIL %s end_ack: ack_o=%b required %b", tag, ack_o, exp_ack ? gbit : 2'b00);
        end
        checks++;
        if (err_o !== (exp_ack ? 2'b00 : gbit)) begin
            errors++;
            $display("FAIL %s end_err: err_o=%b required %b", tag, err_o, exp_ack ? 2'b00 : gbit);
        end
        checks++;
        if ({busy_o, transfer_o, PWRITE_o, PWDATA_o} !== '0) begin
            errors++;
            $display("FAIL %s end_idle: busy=%b transfer=%b pwrite=%b pwdata=%h required all 0", tag,
                     busy_o, transfer_o, PWRITE_o, PWDATA_o);
        end
        checks++;
        if (rdata_o !== exp_rdata) begin
            errors++;
            $display("FAIL %s end_rdata: rdata_o=%h required %h", tag, rdata_o, exp_rdata);
        end

        PREADY_i      = 1'b0;
        uart_run_flag = 1'b1;
        if (!hold)
            req_i = 2'b00;
        if (busy_o)
            do_reset();
    endtask

    task automatic test_reset();
        PRESET        = 1'b1;
        uart_run_flag = 1'b1;
        req_i         = 2'b11;
        step();
        step();
        checks++;
        if ({transfer_o, PWRITE_o, PWDATA_o, ack_o, err_o, rdata_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: outputs=%h required 0",
                     {transfer_o, PWRITE_o, PWDATA_o, ack_o, err_o, rdata_o, busy_o});
        end
        req_i  = 2'b00;
        PRESET = 1'b0;
        step();
        checks++;
        if ({transfer_o, busy_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_idle_no_req: transfer/busy=%b required 00", {transfer_o, busy_o});
        end
        ptr       = 1'b0;
        exp_rdata = '0;
    endtask

    task automatic test_single_write();
        do_xfer(2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 1, -1, 1'b0, 1'b0, "single_write");
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < 4; i++)
            do_xfer(2'b11, 2'(i), DW'($urandom), DW'($urandom), DW'($urandom), 1, -1, 1'b0,
                    (i < 3), "contention");
    endtask

    task automatic test_read();
        do_xfer(2'b10, 2'b00, 8'h11, 8'h22, 8'h3C, 6, -1, 1'b0, 1'b0, "read");
        do_xfer(2'b01, 2'b01, 8'h5A, 8'h00, 8'hEE, 2, -1, 1'b0, 1'b0, "write_keeps_rdata");
    endtask

    task automatic test_abort();
        do_xfer(2'b01, 2'b01, 8'h77, 8'h00, 8'h00, 5, 2, 1'b0, 1'b0, "abort_access");
        do_xfer(2'b10, 2'b00, 8'h00, 8'h88, 8'h99, 1, 0, 1'b0, 1'b0, "abort_setup");
        do_xfer(2'b01, 2'b00, 8'h00, 8'h00, 8'h44, 3, 3, 1'b0, 1'b0, "abort_vs_ready");
    endtask

    task automatic test_drop_mid();
        do_xfer(2'b10, 2'b10, 8'h00, 8'hC3, 8'h00, 3, -1, 1'b1, 1'b0, "drop_mid");
    endtask

`ifdef APB_UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_xfer(2'b01, 2'b01, 8'h12, 8'h00, 8'h00, TO + 1, -1, 1'b0, 1'b0, "timeout_err");
        do_xfer(2'b10, 2'b00, 8'h00, 8'h34, 8'h56, TO, -1, 1'b0, 1'b0, "timeout_ready_wins");
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        req_i         = 2'b10;
        wr_i          = 2'b11;
        wdata1_i      = 8'hF0;
        uart_run_flag = 1'b1;
        PREADY_i      = 1'b0;
        step();
        req_i = 2'b00;
        step();
        step();
        PRESET = 1'b1;
        step();
        checks++;
        if ({transfer_o, PWRITE_o, PWDATA_o, ack_o, err_o, rdata_o, busy_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: outputs=%h required 0",
                     {transfer_o, PWRITE_o, PWDATA_o, ack_o, err_o, rdata_o, busy_o});
        end
        PRESET    = 1'b0;
        ptr       = 1'b0;
        exp_rdata = '0;
        step();
        checks++;
        if ({ack_o, err_o, busy_o} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid_no_pulse: ack/err/busy=%b required 00000", {ack_o, err_o, busy_o});
        end
        do_xfer(2'b11, 2'b01, 8'hAB, 8'hCD, 8'h00, 1, -1, 1'b0, 1'b0, "reset_mid_next_grant");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rq;
            int         ab;
            rq = 2'($urandom_range(1, 3));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
            do_xfer(rq, 2'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                    int'($urandom_range(1, 6)), ab, 1'($urandom), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_read();
        test_abort();
        test_drop_mid();
`ifdef APB_UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
